// File: rtl/outbuf_arbiter.sv
// outbuf_arbiter: round-robin share of the output-buffer write port among PE lanes for one psum pass
module outbuf_arbiter #(
    parameter int NUM_LANES     = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int PSUMS_PER_ROW = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_LANES-1:0]            lane_req,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    input  logic                            outbuf_full,
    output logic [NUM_LANES-1:0]            lane_grant,
    output logic                            outbuf_write,
    output logic [DATA_WIDTH-1:0]           outbuf_wdata,
    output logic                            stall_pipeline,
    output logic [NUM_LANES-1:0]            lane_done,
    output logic                            busy,
    output logic                            psum_done
);
    localparam int CW = $clog2(PSUMS_PER_ROW + 1);
    localparam int PW = $clog2(NUM_LANES);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         rr_ptr, gidx, idx;
    logic [CW-1:0]         cnt [NUM_LANES];
    logic [DATA_WIDTH-1:0] lane_word [NUM_LANES];
    logic [NUM_LANES-1:0]  eligible, onehot, done_nxt;
    logic                  found, active, fin;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_word
        assign lane_word[i] = lane_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // first eligible lane at or after rr_ptr, wrapping around
    always_comb begin
        eligible = lane_req & ~lane_done;
        found    = 1'b0;
        gidx     = '0;
        idx      = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_LANES);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign active         = state == RUN && !outbuf_full && found;
    assign onehot         = active ? NUM_LANES'(1) << gidx : '0;
    assign lane_grant     = onehot;
    assign outbuf_write   = active;
    assign outbuf_wdata   = active ? lane_word[gidx] : '0;
    assign stall_pipeline = state == RUN && outbuf_full && |eligible;
    assign fin            = active && cnt[gidx] == CW'(PSUMS_PER_ROW - 1);
    assign done_nxt       = lane_done | (fin ? onehot : '0);
    assign busy           = state != IDLE;
    assign psum_done      = state == DONE;

    // pass sequencing, per-lane write counts and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lane_done <= '0;
            for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state     <= RUN;
                rr_ptr    <= '0;
                lane_done <= '0;
                for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
            end
        end else if (state == RUN) begin
            if (active) begin
                cnt[gidx] <= cnt[gidx] + 1'b1;
                rr_ptr    <= gidx == PW'(NUM_LANES - 1) ? '0 : gidx + 1'b1;
            end
            lane_done <= done_nxt;
            if (&done_nxt) state <= DONE;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_outbuf_arbiter.sv
// tb_outbuf_arbiter: directed passes checked against a per-lane write-count model every cycle
module tb_outbuf_arbiter;
    localparam int N = 4, DW = 16, P = 2;

    logic            clk = 0, rst = 1, start = 0, outbuf_full = 0;
    logic [N-1:0]    lane_req = '0;
    logic [N*DW-1:0] lane_data = '0;
    logic [N-1:0]    lane_grant, lane_done;
    logic            outbuf_write, stall_pipeline, busy, psum_done;
    logic [DW-1:0]   outbuf_wdata;

    outbuf_arbiter #(.NUM_LANES(N), .DATA_WIDTH(DW), .PSUMS_PER_ROW(P)) dut (
        .clk(clk), .rst(rst), .start(start), .lane_req(lane_req), .lane_data(lane_data),
        .outbuf_full(outbuf_full), .lane_grant(lane_grant), .outbuf_write(outbuf_write),
        .outbuf_wdata(outbuf_wdata), .stall_pipeline(stall_pipeline), .lane_done(lane_done),
        .busy(busy), .psum_done(psum_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: pass phase (0 idle, 1 running, 2 finishing), writes delivered per lane, last lane served
    int m_phase = 0, m_last = N - 1, nx_phase = 0, nx_last = N - 1;
    int m_cnt [N], nx_cnt [N];
    bit m_valid = 0;

    always @(negedge clk) begin
        logic [N-1:0]  eg, ed_done;
        logic [DW-1:0] ed;
        int            g, j;
        bit            anyel, all;
        eg = '0; ed = '0; ed_done = '0; g = -1; anyel = 0;
        for (int i = 0; i < N; i++) begin
            if (lane_req[i] && m_cnt[i] < P) anyel = 1;
            ed_done[i] = (m_cnt[i] == P);
        end
        if (m_phase == 1 && !outbuf_full)
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && lane_req[j] && m_cnt[j] < P) g = j;
            end
        if (g >= 0) begin
            eg[g] = 1'b1;
            ed    = lane_data[g*DW +: DW];
        end
        if (m_valid) begin
            chk("grant", lane_grant, eg);
            chk("write", outbuf_write, g >= 0);
            chk("wdata", outbuf_wdata, ed);
            chk("stall", stall_pipeline, m_phase == 1 && outbuf_full && anyel);
            chk("lane_done", lane_done, ed_done);
            chk("busy", busy, m_phase != 0);
            chk("psum_done", psum_done, m_phase == 2);
        end
        nx_cnt = m_cnt; nx_last = m_last; nx_phase = m_phase;
        if (rst || (m_phase == 0 && start)) begin
            nx_phase = rst ? 0 : 1;
            nx_last  = N - 1;
            for (int i = 0; i < N; i++) nx_cnt[i] = 0;
        end else if (m_phase == 1) begin
            if (g >= 0) begin
                nx_cnt[g]++;
                nx_last = g;
            end
            all = 1;
            for (int i = 0; i < N; i++) if (nx_cnt[i] != P) all = 0;
            if (all) nx_phase = 2;
        end else if (m_phase == 2) begin
            nx_phase = 0;
        end
    end

    always @(posedge clk) begin
        m_phase <= nx_phase;
        m_last  <= nx_last;
        m_cnt   <= nx_cnt;
        if (rst) m_valid <= 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] bp_tab [1:11] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [N-1:0] sp_tab [4:9]  = '{4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2};

    initial begin
        // reset with random inputs and a start pulse that must be ignored
        lane_req = N'($urandom); lane_data = {$urandom, $urandom}; outbuf_full = 1'($urandom);
        tick;
        lane_req = N'($urandom); lane_data = {$urandom, $urandom}; outbuf_full = 0; start = 1;
        @(negedge clk);
        chk("rst_grant", lane_grant, 0);
        chk("rst_wdata", outbuf_wdata, 0);
        chk("rst_busy", busy, 0);
        tick;
        rst = 0; start = 0; lane_req = '0; outbuf_full = 0;
        @(negedge clk);
        chk("rst_start_ignored", busy, 0);
        tick;

        // full rotation
        lane_data = {16'd3, 16'd2, 16'd1, 16'd0};
        lane_req = 4'hF; start = 1;
        tick;
        start = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("rot_grant", lane_grant, 4'h1 << ((c - 1) % 4));
            chk("rot_wdata", outbuf_wdata, (c - 1) % 4);
            tick;
        end
        @(negedge clk);
        chk("rot_psum_done", psum_done, 1);
        chk("rot_lane_done", lane_done, 4'hF);
        tick;
        @(negedge clk);
        chk("rot_busy_off", busy, 0);
        chk("rot_pulse_once", psum_done, 0);

        // backpressure in cycles 3-5
        start = 1;
        tick;
        start = 0;
        for (int c = 1; c <= 11; c++) begin
            outbuf_full = (c >= 3 && c <= 5);
            @(negedge clk);
            chk("bp_grant", lane_grant, bp_tab[c]);
            if (outbuf_full) chk("bp_stall", stall_pipeline, 1);
            tick;
        end
        outbuf_full = 0;
        @(negedge clk);
        chk("bp_psum_done", psum_done, 1);
        tick;
        @(negedge clk);
        chk("bp_busy_off", busy, 0);

        // sparse: only lane 2, then the rest join
        lane_req = 4'b0100; start = 1;
        tick;
        start = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("sp_grant", lane_grant, c < 3 ? 4'b0100 : 4'b0000);
            if (c == 3) chk("sp_lane_done", lane_done, 4'b0100);
            tick;
        end
        lane_req = 4'hF;
        for (int c = 4; c <= 9; c++) begin
            @(negedge clk);
            chk("sp_grant", lane_grant, sp_tab[c]);
            tick;
        end
        @(negedge clk);
        chk("sp_psum_done", psum_done, 1);
        tick;

        // start pulsed while running must not clear progress
        start = 1;
        tick;
        for (int c = 1; c <= 8; c++) begin
            start = (c == 6);
            @(negedge clk);
            chk("ign_grant", lane_grant, 4'h1 << ((c - 1) % 4));
            if (c == 7) chk("ign_lane_done", lane_done, 4'b0011);
            tick;
        end
        start = 0;
        @(negedge clk);
        chk("ign_psum_done", psum_done, 1);
        tick;

        // reset in cycle 4 abandons the pass
        start = 1;
        tick;
        start = 0;
        repeat (3) tick;
        rst = 1;
        tick;
        rst = 0;
        @(negedge clk);
        chk("mr_busy", busy, 0);
        chk("mr_lane_done", lane_done, 0);
        tick;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mr_no_psum_done", psum_done, 0);
            tick;
        end
        start = 1;
        tick;
        start = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("mr_grant", lane_grant, 4'h1 << ((c - 1) % 4));
            tick;
        end
        @(negedge clk);
        chk("mr_psum_done", psum_done, 1);
        repeat (3) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
